data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- Accepts one request at a time over a valid/ready request channel, inserts a programmable number of wait states, then performs the byte-enabled write or word read.
- Returns a registered response on a valid/ready response channel.
- Sits between the core's load/store unit (the initiator) and on-chip data storage; it is the far end of the load/store interface.

---
 rtl/riscv_mem_pkg.sv | 35 +++
 rtl/data_mem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths,
// response codes and the byte-lane merge helper used by the storage array.
package riscv_mem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array with synchronous byte-enabled write and
// combinational read. Contents are deliberately not reset.
import riscv_mem_pkg::*;

module data_mem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  CLK,
  input  logic                  WE,
  input  logic [BE_W-1:0]       BE,
  input  logic [DEPTH_LOG2-1:0] IDX,
  input  logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W-1:0]     RDATA
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  // Byte-lane write of the addressed word; disabled lanes keep their value.
  always_ff @(posedge CLK) begin
    if (WE) begin
      r_mem[IDX] <= merge_lanes(r_mem[IDX], WDATA, BE);
    end
  end

  assign RDATA = r_mem[IDX];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port. Accepts one request at a
// time, waits WAIT_CYCLES cycles, performs the access, and holds a registered
// response until the initiator takes it.
// Optional build macro: DATA_MEM_ALIGN_CHECK_EN (misaligned addresses error).
import riscv_mem_pkg::*;

module data_mem_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [31:0]       REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [BE_W-1:0]   REQ_BE,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_INIT  = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam longint      SPAN      = longint'(4) << DEPTH_LOG2;

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
    end
    if ((longint'(BASE_ADDR) % SPAN) != 0) begin : g_bad_base
      $error("data_mem_responder: BASE_ADDR must be aligned to the memory span");
    end
  endgenerate

  state_e                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [BE_W-1:0]       r_be;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_access;
  logic                  w_acc_we;
  logic [31:0]           w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic [BE_W-1:0]       w_acc_be;
  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_range_err;
  logic                  w_align_err;
  logic                  w_err;
  logic                  w_mem_we;
  logic [DATA_W-1:0]     w_mem_rdata;
  logic [DATA_W-1:0]     w_rsp_rdata_next;
  logic                  w_rsp_err_next;
  logic                  w_unused_lsbs;

  // Ready only while idle and out of reset; no overlap with a pending response.
  assign REQ_READY = (r_state == S_IDLE) & ~RST;

  // With no wait states the access happens on the handshake edge itself, so it
  // must use the live request fields rather than the latched copy.
  assign w_acc_we    = ZERO_WAIT ? REQ_WE    : r_we;
  assign w_acc_addr  = ZERO_WAIT ? REQ_ADDR  : r_addr;
  assign w_acc_wdata = ZERO_WAIT ? REQ_WDATA : r_wdata;
  assign w_acc_be    = ZERO_WAIT ? REQ_BE    : r_be;
  assign w_access    = ZERO_WAIT ? (REQ_VALID & REQ_READY)
                                 : ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // Unsigned subtraction: addresses below the base wrap high and fail the range test.
  assign w_off       = w_acc_addr - BASE_ADDR;
  assign w_range_err = |w_off[31:DEPTH_LOG2+2];
  assign w_idx       = w_off[DEPTH_LOG2+1:2];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_align_err = |w_acc_addr[1:0];
`else
  assign w_align_err = 1'b0;
`endif

  assign w_unused_lsbs = ^{w_off[1:0], w_acc_addr[1:0]};

  assign w_err            = w_align_err | w_range_err;
  assign w_mem_we         = w_access & w_acc_we & ~w_err;
  assign w_rsp_rdata_next = (w_acc_we | w_err) ? {DATA_W{1'b0}} : w_mem_rdata;
  assign w_rsp_err_next   = w_err ? RESP_ERR : RESP_OK;

  data_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK   (CLK),
    .WE    (w_mem_we),
    .BE    (w_acc_be),
    .IDX   (w_idx),
    .WDATA (w_acc_wdata),
    .RDATA (w_mem_rdata)
  );

  // Request/wait/response sequencing with registered response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= {DATA_W{1'b0}};
      r_be        <= {BE_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            r_we    <= REQ_WE;
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
            r_be    <= REQ_BE;
            if (ZERO_WAIT) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_rdata_next;
              r_rsp_err   <= w_rsp_err_next;
              r_state     <= S_RESP;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_err   <= w_rsp_err_next;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: one instance with two wait
// states, one with none, sharing request data lines.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        a_req_valid, a_rsp_ready, a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_rsp_ready, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  bit          cur;
  logic        s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata;

  int n_cmp = 0;
  int n_mis = 0;
  bit align_on;

  typedef struct {
    bit          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  assign s_req_ready = cur ? b_req_ready : a_req_ready;
  assign s_rsp_valid = cur ? b_rsp_valid : a_rsp_valid;
  assign s_rsp_err   = cur ? b_rsp_err   : a_rsp_err;
  assign s_rsp_rdata = cur ? b_rsp_rdata : a_rsp_rdata;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
    .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready),
    .RSP_RDATA(a_rsp_rdata), .RSP_ERR(a_rsp_err)
  );

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut_w0 (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
    .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
    .RSP_RDATA(b_rsp_rdata), .RSP_ERR(b_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit sel, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.sel = sel; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // Present a request, handshake it, then count edges until the response shows.
  task automatic send_req(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, output int lat);
    cur = sel;
    @(negedge CLK);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    #1;
    chk("req_ready_idle", 32'(s_req_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    lat = 0;
    while (!s_rsp_valid && lat < 40) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
  endtask

  // Take the pending response and confirm the responder returns to idle.
  task automatic accept_rsp();
    if (cur) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    #1;
    chk("rsp_valid_cleared", 32'(s_rsp_valid), 32'd0);
    chk("rsp_rdata_cleared", s_rsp_rdata, 32'd0);
    chk("rsp_err_cleared", 32'(s_rsp_err), 32'd0);
    chk("req_ready_after_rsp", 32'(s_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_lat;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    align_on = 1'b1;
`else
    align_on = 1'b0;
`endif

    // sel 0: two wait states; sel 1: zero wait states
    add(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0);
    add(0, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0);
    add(0, 1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'hF, 32'h0000_0000, 1'b0);
    add(0, 1'b1, 32'h0000_0080, 32'h1122_3344, 4'b0101, 32'h0000_0000, 1'b0);
    add(0, 1'b0, 32'h0000_0080, 32'h0000_0000, 4'h0, 32'hAA22_CC44, 1'b0);
    add(0, 1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1);
    add(0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0);
    add(0, 1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0);
    add(0, 1'b1, 32'h0000_03FC, 32'h0BAD_0BAD, 4'h0, 32'h0000_0000, 1'b0);
    add(0, 1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0);
    add(0, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1);
    add(0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0);
    add(0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0);
    add(0, 1'b0, 32'h0000_0042, 32'h0000_0000, 4'h0,
        align_on ? 32'h0000_0000 : 32'h1234_5678, align_on);
    add(1, 1'b1, 32'h0000_0040, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0);
    add(1, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, align_on);
    add(1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0,
        align_on ? 32'h0102_0304 : 32'hFFFF_FFFF, 1'b0);
    add(1, 1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1);

    RST = 1'b1;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    a_req_valid = 1'b0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0;
    cur = 1'b0;
    #1;
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    chk("rst_w0_req_ready", 32'(b_req_ready), 32'd0);
    chk("rst_w0_rsp_valid", 32'(b_rsp_valid), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("post_rst_w0_req_ready", 32'(b_req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      send_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat);
      exp_lat = vecs[i].sel ? 0 : 2;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("v%0d_rdata", i), s_rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(s_rsp_err), 32'(vecs[i].exp_err));
      accept_rsp();
    end

    // Backpressure: response must hold steady while the initiator stalls.
    send_req(0, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, lat);
    chk("bp_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(a_rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rdata", k), a_rsp_rdata, 32'h1234_5678);
      chk($sformatf("bp%0d_err", k), 32'(a_rsp_err), 32'd0);
      chk($sformatf("bp%0d_req_ready", k), 32'(a_req_ready), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
    end
    accept_rsp();

    // Reset during the wait states drops the pending store.
    cur = 1'b0;
    @(negedge CLK);
    req_we = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
    a_req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    a_req_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("midwait_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("midwait_rst_req_ready", 32'(a_req_ready), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midwait_release_req_ready", 32'(a_req_ready), 32'd1);
    chk("midwait_release_rsp_valid", 32'(a_rsp_valid), 32'd0);
    send_req(0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, lat);
    chk("midwait_load_latency", 32'(lat), 32'd2);
    chk("midwait_load_rdata", a_rsp_rdata, 32'h0000_0000);
    chk("midwait_load_err", 32'(a_rsp_err), 32'd0);
    accept_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
